// File: rtl/ahb_slave_interface.sv
// ahb_slave_interface: AHB front end of the AHB2APB bridge; pipelines address/data/direction, decodes slots and answers OKAY or a two-cycle ERROR.
module ahb_slave_interface #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int SLOT_SHIFT = 26
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic [31:0] prdata,
  input  logic        ready_in,
  output logic        valid,
  output logic [2:0]  tempselx,
  output logic [31:0] haddr1,
  output logic [31:0] haddr2,
  output logic [31:0] hwdata1,
  output logic [31:0] hwdata2,
  output logic        hwrite_reg,
  output logic        hwrite_reg1,
  output logic [31:0] hrdata,
  output logic [1:0]  hresp,
  output logic        hreadyout
);
  typedef enum logic [1:0] {OKAY, ERR1, ERR2} state_t;
  localparam logic [31:0] SLOT_LIM = 32'(3) << SLOT_SHIFT;
  state_t state_q, state_d;
  logic [31:0] haddr1_q, haddr1_d, haddr2_q, haddr2_d, hwdata1_q, hwdata1_d, hwdata2_q, hwdata2_d;
  logic hwrite_reg_q, hwrite_reg_d, hwrite_reg1_q, hwrite_reg1_d;
  logic [31:0] off, slot;
  logic in_range, active;
  always_comb begin
    off = haddr - BASE_ADDR;
    slot = off >> SLOT_SHIFT;
    in_range = (haddr >= BASE_ADDR) && (off < SLOT_LIM);
    tempselx = !in_range ? 3'b000 : slot == 32'd0 ? 3'b001 : slot == 32'd1 ? 3'b010 : 3'b100;
    active = hreadyin & htrans[1];
  end
  always_comb begin
    haddr1_d = haddr;
    haddr2_d = haddr1_q;
    hwdata1_d = hwdata;
    hwdata2_d = hwdata1_q;
    hwrite_reg_d = hwrite;
    hwrite_reg1_d = hwrite_reg_q;
  end
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      haddr1_q <= '0;
      haddr2_q <= '0;
      hwdata1_q <= '0;
      hwdata2_q <= '0;
      hwrite_reg_q <= 1'b0;
      hwrite_reg1_q <= 1'b0;
    end else begin
      haddr1_q <= haddr1_d;
      haddr2_q <= haddr2_d;
      hwdata1_q <= hwdata1_d;
      hwdata2_q <= hwdata2_d;
      hwrite_reg_q <= hwrite_reg_d;
      hwrite_reg1_q <= hwrite_reg1_d;
    end
  end
  always_ff @(posedge hclk) begin
    if (hresetn) state_q <= OKAY;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == ERR1 ? ERR2 :
              state_q == ERR2 ? OKAY :
              (active && !in_range) ? ERR1 : OKAY;
  end
  always_comb begin
    hresp = state_q == OKAY ? 2'b00 : 2'b01;
    hreadyout = state_q == OKAY ? ready_in : state_q == ERR2;
    valid = active & in_range & (state_q == OKAY) & ~hresetn;
    hrdata = prdata;
    haddr1 = haddr1_q;
    haddr2 = haddr2_q;
    hwdata1 = hwdata1_q;
    hwdata2 = hwdata2_q;
    hwrite_reg = hwrite_reg_q;
    hwrite_reg1 = hwrite_reg1_q;
  end
endmodule

// File: tb/tb_ahb_slave_interface.sv
// tb_ahb_slave_interface: directed stimulus, per-cycle model comparison and literal spot checks for ahb_slave_interface.
module tb_ahb_slave_interface;
  logic hclk = 1'b0, hresetn = 1'b1, hwrite = 1'b0, hreadyin = 1'b1, ready_in = 1'b1;
  logic [1:0] htrans = 2'b00;
  logic [31:0] haddr = '0, hwdata = '0, prdata = '0;
  logic valid, hwrite_reg, hwrite_reg1, hreadyout;
  logic [2:0] tempselx;
  logic [31:0] haddr1, haddr2, hwdata1, hwdata2, hrdata;
  logic [1:0] hresp;
  int checks = 0, failures = 0;
  logic started = 1'b0;
  logic [31:0] m_addr [2], m_data [2];
  logic m_wr [2];
  int err_left = 0;
  ahb_slave_interface dut (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hreadyin(hreadyin), .htrans(htrans),
    .haddr(haddr), .hwdata(hwdata), .prdata(prdata), .ready_in(ready_in), .valid(valid),
    .tempselx(tempselx), .haddr1(haddr1), .haddr2(haddr2), .hwdata1(hwdata1), .hwdata2(hwdata2),
    .hwrite_reg(hwrite_reg), .hwrite_reg1(hwrite_reg1), .hrdata(hrdata), .hresp(hresp), .hreadyout(hreadyout)
  );
  always #5 hclk = ~hclk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endtask
  function automatic logic in_win(input logic [31:0] a);
    return a >= 32'h8000_0000 && a < 32'h8000_0000 + 3 * 32'h0400_0000;
  endfunction
  function automatic logic [2:0] sel_of(input logic [31:0] a);
    return in_win(a) ? 3'(1 << ((a - 32'h8000_0000) / 32'h0400_0000)) : 3'b000;
  endfunction
  always @(posedge hclk) begin
    started <= 1'b1;
    if (hresetn) begin
      m_addr[0] <= '0; m_addr[1] <= '0; m_data[0] <= '0; m_data[1] <= '0;
      m_wr[0] <= 1'b0; m_wr[1] <= 1'b0; err_left <= 0;
    end else begin
      m_addr[0] <= haddr; m_addr[1] <= m_addr[0];
      m_data[0] <= hwdata; m_data[1] <= m_data[0];
      m_wr[0] <= hwrite; m_wr[1] <= m_wr[0];
      err_left <= err_left > 0 ? err_left - 1 : (hreadyin && htrans[1] && !in_win(haddr)) ? 2 : 0;
    end
  end
  always @(negedge hclk) if (started) begin
    chk("m_valid", 32'(valid), 32'(err_left == 0 && !hresetn && hreadyin && htrans[1] && in_win(haddr)));
    chk("m_tempselx", 32'(tempselx), 32'(sel_of(haddr)));
    chk("m_hresp", 32'(hresp), err_left > 0 ? 32'd1 : 32'd0);
    chk("m_hreadyout", 32'(hreadyout), 32'(err_left == 0 ? ready_in : err_left == 1));
    chk("m_hrdata", hrdata, prdata);
    chk("m_haddr1", haddr1, m_addr[0]);
    chk("m_haddr2", haddr2, m_addr[1]);
    chk("m_hwdata1", hwdata1, m_data[0]);
    chk("m_hwdata2", hwdata2, m_data[1]);
    chk("m_hwrite_reg", 32'(hwrite_reg), 32'(m_wr[0]));
    chk("m_hwrite_reg1", 32'(hwrite_reg1), 32'(m_wr[1]));
  end
  task automatic drive(input logic rst, input logic [1:0] tr, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic rdy, input logic [31:0] prd);
    @(posedge hclk); #1;
    hresetn = rst; htrans = tr; hwrite = wr; haddr = a; hwdata = wd; ready_in = rdy; prdata = prd;
    @(negedge hclk); #1;
  endtask
  initial begin
    drive(1, 2'b10, 1, 32'h8000_0000, 0, 1, 0);
    chk("rst_valid", 32'(valid), 0);
    drive(1, 2'b10, 1, 32'h8000_0004, 0, 1, 0);
    chk("rst_pipe", haddr1, 0);
    chk("rst_hresp", 32'(hresp), 0);
    drive(0, 2'b10, 1, 32'h8000_0001, 32'h11, 1, 0);
    chk("wr_valid", 32'(valid), 1);
    chk("wr_sel", 32'(tempselx), 32'b001);
    drive(0, 2'b00, 1, 32'h0000_0000, 32'h80, 1, 0);
    chk("wr_haddr1", haddr1, 32'h8000_0001);
    chk("wr_hwrite_reg", 32'(hwrite_reg), 1);
    drive(0, 2'b00, 0, 32'h0000_0000, 32'h0, 1, 0);
    chk("wr_haddr2", haddr2, 32'h8000_0001);
    chk("wr_hwdata1", hwdata1, 32'h80);
    chk("wr_hwrite_reg1", 32'(hwrite_reg1), 1);
    drive(0, 2'b10, 0, 32'h8000_0001, 0, 0, 32'hDEAD_BEEF);
    chk("rd_valid", 32'(valid), 1);
    chk("rd_hrdata", hrdata, 32'hDEAD_BEEF);
    chk("rd_hready0", 32'(hreadyout), 0);
    drive(0, 2'b00, 0, 32'h0, 0, 0, 32'hDEAD_BEEF);
    chk("rd_hready1", 32'(hreadyout), 0);
    chk("rd_hwrite_reg", 32'(hwrite_reg), 0);
    drive(0, 2'b00, 0, 32'h0, 0, 1, 0);
    chk("rd_hready2", 32'(hreadyout), 1);
    drive(0, 2'b10, 1, 32'h83FF_FFFF, 0, 1, 0);
    chk("sw0", 32'(tempselx), 32'b001);
    drive(0, 2'b11, 1, 32'h8400_0000, 0, 1, 0);
    chk("sw1", 32'(tempselx), 32'b010);
    chk("sw1_valid", 32'(valid), 1);
    drive(0, 2'b11, 1, 32'h8BFF_FFFF, 0, 1, 0);
    chk("sw2", 32'(tempselx), 32'b100);
    drive(0, 2'b01, 1, 32'h8000_0000, 0, 1, 0);
    chk("busy_valid", 32'(valid), 0);
    drive(0, 2'b00, 1, 32'h0, 0, 1, 0);
    chk("busy_hresp", 32'(hresp), 0);
    drive(0, 2'b10, 1, 32'h8C00_0000, 0, 1, 0);
    chk("oor_valid", 32'(valid), 0);
    chk("oor_sel", 32'(tempselx), 0);
    drive(0, 2'b00, 1, 32'h0, 0, 1, 0);
    chk("err1_hresp", 32'(hresp), 1);
    chk("err1_ready", 32'(hreadyout), 0);
    drive(0, 2'b10, 1, 32'h8000_0000, 0, 1, 0);
    chk("err2_hresp", 32'(hresp), 1);
    chk("err2_ready", 32'(hreadyout), 1);
    chk("err2_valid", 32'(valid), 0);
    drive(0, 2'b00, 1, 32'h0, 0, 1, 0);
    chk("ok_hresp", 32'(hresp), 0);
    drive(0, 2'b10, 0, 32'h7FFF_FFFF, 0, 0, 0);
    chk("lo_ready", 32'(hreadyout), 0);
    chk("lo_valid", 32'(valid), 0);
    drive(0, 2'b00, 0, 32'h0, 0, 1, 0);
    chk("lo_err1", 32'(hresp), 1);
    drive(0, 2'b00, 0, 32'h0, 0, 1, 0);
    drive(0, 2'b10, 1, 32'h8C00_0000, 32'h55, 1, 0);
    drive(1, 2'b10, 1, 32'h8000_0010, 32'h66, 0, 0);
    chk("rst_mid_hresp_before", 32'(hresp), 1);
    chk("rst_mid_valid", 32'(valid), 0);
    drive(0, 2'b00, 0, 32'h0, 0, 0, 0);
    chk("rst_mid_hresp", 32'(hresp), 0);
    chk("rst_mid_ready", 32'(hreadyout), 0);
    chk("rst_mid_haddr1", haddr1, 0);
    chk("rst_mid_hwdata1", hwdata1, 0);
    for (int i = 0; i < 8; i++) drive(0, 2'(i), 1'(i), 32'h8000_0000 + 32'(i) * 32'h0200_0000, 32'(i * 7), 1'(i >> 1), 32'(i));
    drive(0, 2'b00, 0, 32'h0, 0, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ahb_slave_interface.md
Name: ahb_slave_interface

Overview:
- AHB-side front end of the AHB2APB bridge; sits directly downstream of the AHB master and consumes its address-phase and data-phase signals.
- Pipelines address, write data and direction, decodes the address into one of three APB peripheral selects, and raises the transfer-valid strobe for the APB controller FSM.
- Drives hreadyout/hresp/hrdata back to the master, including a two-cycle AHB ERROR response for out-of-range accesses.

Parameters:
- BASE_ADDR, 32'h8000_0000, start of bridge address window.
- SLOT_SHIFT, 26, log2 of per-peripheral slot size (64 MB). Slot n covers BASE_ADDR + n*2^SLOT_SHIFT; n = 0..2.

Ports:
- hclk  input  1  bridge clock; all state updates on rising edge.
- hresetn  input  1  reset, synchronous, active-high (1 = reset), sampled on rising hclk.
- hwrite  input  1  master direction, 1 = write.
- hreadyin  input  1  bus ready from master side.
- htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- haddr  input  32  master address.
- hwdata  input  32  master write data.
- prdata  input  32  read data returned by APB controller.
- ready_in  input  1  APB controller ready; stretches hreadyout.
- valid  output  1  accepted in-range transfer this cycle (combinational).
- tempselx  output  3  one-hot slot decode of current haddr (combinational).
- haddr1, haddr2  output  32  haddr delayed 1 and 2 cycles.
- hwdata1, hwdata2  output  32  hwdata delayed 1 and 2 cycles.
- hwrite_reg, hwrite_reg1  output  1  hwrite delayed 1 and 2 cycles.
- hrdata  output  32  read data to master.
- hresp  output  2  00 OKAY, 01 ERROR.
- hreadyout  output  1  slave ready to master.

Behaviour:
- Reset (hresetn=1 at edge): all pipeline registers 0, FSM to OKAY. Outputs then: hresp=00, hreadyout=ready_in, valid=0 while hresetn=1.
- Pipeline: every edge not in reset, haddr1<=haddr, haddr2<=haddr1, hwdata1<=hwdata, hwdata2<=hwdata1, hwrite_reg<=hwrite, hwrite_reg1<=hwrite_reg. No enables.
- Decode (combinational on haddr): in_range = haddr in [BASE, BASE+3*2^SLOT_SHIFT). Slot 0 -> tempselx=001, slot 1 -> 010, slot 2 -> 100, else 000.
- active = hreadyin & htrans[1] (NONSEQ or SEQ); IDLE and BUSY are never active.
- valid = active & in_range & state==OKAY & hresetn==0.
- hrdata = prdata, combinational pass-through.
- FSM states: OKAY, ERR1, ERR2.
  - OKAY: hresp=00, hreadyout=ready_in. If active & !in_range -> ERR1, else stay.
  - ERR1: hresp=01, hreadyout=0, valid=0; unconditionally -> ERR2.
  - ERR2: hresp=01, hreadyout=1, valid=0; unconditionally -> OKAY. An address phase presented during ERR2 is ignored; the master must reissue it.
- Reset mid-error: reset has priority; next state is OKAY, hresp=00 the cycle after reset asserts.
- Boundaries: BASE+0x03FF_FFFF -> 001; BASE+0x0400_0000 -> 010; BASE+0x0BFF_FFFF -> 100; BASE+0x0C00_0000 and BASE-1 -> out of range.
- Simultaneous ready_in=0 and out-of-range request in OKAY: hreadyout=0 that cycle, ERR1 still entered.

Test Plan:
- Single write: hwrite=1, htrans=10, hreadyin=1, haddr=0x8000_0001; next cycle htrans=00, hwdata=0x80 -> valid=1 and tempselx=001 in address cycle; haddr1=0x8000_0001 after edge 1, haddr2 after edge 2; hwdata1=0x80 after the edge following data phase; hwrite_reg=1 then hwrite_reg1=1; hresp=00 throughout.
- Single read: hwrite=0, haddr=0x8000_0001, prdata=0xDEAD_BEEF -> valid=1, hwrite_reg=0, hrdata=0xDEAD_BEEF same cycle, hreadyout tracks ready_in (drive 0 for 2 cycles -> hreadyout low for 2 cycles).
- Slot decode sweep: 0x83FF_FFFF -> 001; 0x8400_0000 -> 010; 0x8BFF_FFFF -> 100, all valid=1; htrans=01 at 0x8000_0000 -> valid=0, no error.
- Out-of-range: NONSEQ at 0x8C00_0000 -> valid=0; next cycle hresp=01, hreadyout=0; following cycle hresp=01, hreadyout=1; then hresp=00; NONSEQ at 0x8000_0000 presented during ERR2 -> valid=0.
- Reset: assert hresetn=1 during ERR1 -> next cycle hresp=00, hreadyout=ready_in, all haddr/hwdata/hwrite pipeline outputs 0; valid=0 while asserted even with in-range NONSEQ.
